// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and constants for the data-memory arbiter slice.
// Holds the arbiter FSM state enum, owner encodings, default bus widths and
// the legal ranges of the latency/starvation parameters.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DMA  = 1'b1;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam int READ_LAT_MIN   = 1;
  localparam int READ_LAT_MAX   = 4;
  localparam int STARVE_MAX_MIN = 1;
  localparam int STARVE_MAX_MAX = 15;

  // Width that holds any legal STARVE_MAX value
  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mips_arb_starve_cnt.sv
// mips_arb_starve_cnt: saturating count of consecutive core grants made while
// the DMA side was waiting. sat tells the arbiter that DMA must win next.
module mips_arb_starve_cnt
  import mips_mem_pkg::*;
#(
  parameter int MAX = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [STARVE_CNT_W-1:0] cnt;

  // Clear wins over increment; the count sticks at MAX until cleared
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + STARVE_CNT_W'(1);
    end
  end

  assign sat = (cnt == STARVE_CNT_W'(MAX));

endmodule

// File: rtl/mips_dmem_arbiter.sv
// mips_dmem_arbiter: shares the single data-memory port between the core
// load/store path and a DMA/program-loader requester. One access at a time:
// IDLE (arbitrate) -> ISSUE (strobe) -> WAIT (reads only) -> RESP (ack).
// Optional build macro MIPS_DMEM_ARB_ALIGN_CHK_EN adds core_err/dma_err and
// rejects non-word-aligned addresses without touching memory.
module mips_dmem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int READ_LAT   = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic              GlobalClock,
  input  logic              GlobalReset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ack,
  output logic              core_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MIPS_DMEM_ARB_ALIGN_CHK_EN
  ,
  output logic              core_err,
  output logic              dma_err
`endif
);

  arb_state_t        state_q, state_d;
  logic              owner_q;
  logic              we_q;
  logic [2:0]        wait_cnt_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] core_rdata_q;
  logic [DATA_W-1:0] dma_rdata_q;

  logic              grant_dma;
  logic              any_req;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              misaligned;
  logic              starve_sat;
  logic              cnt_inc;
  logic              cnt_clr;
  logic              rd_done;

`ifdef MIPS_DMEM_ARB_ALIGN_CHK_EN
  logic              err_q;
`endif

  // Core has fixed priority unless the DMA side has been passed over too often
  always_comb begin
    grant_dma = dma_req & (~core_req | starve_sat);
    any_req   = core_req | dma_req;
    sel_we    = grant_dma ? dma_we    : core_we;
    sel_addr  = grant_dma ? dma_addr  : core_addr;
    sel_wdata = grant_dma ? dma_wdata : core_wdata;
  end

`ifdef MIPS_DMEM_ARB_ALIGN_CHK_EN
  assign misaligned = (sel_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Starvation accounting only moves on arbitration (IDLE) cycles
  assign cnt_clr = (state_q == IDLE) & (~dma_req | grant_dma);
  assign cnt_inc = (state_q == IDLE) & core_req & dma_req & ~grant_dma;

  mips_arb_starve_cnt #(
    .MAX(STARVE_MAX)
  ) u_starve_cnt (
    .clock(GlobalClock),
    .reset(GlobalReset),
    .inc  (cnt_inc),
    .clr  (cnt_clr),
    .sat  (starve_sat)
  );

  assign rd_done = (state_q == WAIT) && (wait_cnt_q == 3'(READ_LAT - 1));

  // Next-state logic: rejected (misaligned) requests jump straight to RESP
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = misaligned ? RESP : ISSUE;
      ISSUE:   state_d = we_q ? RESP : WAIT;
      WAIT:    if (rd_done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, latched access, wait counter and per-owner read data
  always_ff @(posedge GlobalClock) begin
    if (GlobalReset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_CORE;
      we_q         <= 1'b0;
      wait_cnt_q   <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_rdata_q <= '0;
      dma_rdata_q  <= '0;
`ifdef MIPS_DMEM_ARB_ALIGN_CHK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        owner_q <= grant_dma;
        we_q    <= sel_we;
`ifdef MIPS_DMEM_ARB_ALIGN_CHK_EN
        err_q   <= misaligned;
`endif
        if (!misaligned) begin
          mem_addr_q  <= sel_addr;
          mem_wdata_q <= sel_wdata;
        end
      end
      if (state_q == ISSUE) begin
        wait_cnt_q <= '0;
      end else if (state_q == WAIT) begin
        wait_cnt_q <= wait_cnt_q + 3'd1;
      end
      if (rd_done) begin
        if (owner_q == OWN_DMA) begin
          dma_rdata_q <= mem_rdata;
        end else begin
          core_rdata_q <= mem_rdata;
        end
      end
    end
  end

  assign mem_re     = (state_q == ISSUE) & ~we_q;
  assign mem_we     = (state_q == ISSUE) & we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_ack   = (state_q == RESP) & (owner_q == OWN_CORE);
  assign dma_ack    = (state_q == RESP) & (owner_q == OWN_DMA);
  assign core_rdata = core_rdata_q;
  assign dma_rdata  = dma_rdata_q;
  assign core_stall = core_req & ~core_ack;

`ifdef MIPS_DMEM_ARB_ALIGN_CHK_EN
  assign core_err = core_ack & err_q;
  assign dma_err  = dma_ack & err_q;
`endif

endmodule

// File: tb/tb_mips_dmem_arbiter.sv
// tb_mips_dmem_arbiter: self-checking bench for mips_dmem_arbiter.
// Instance u_dut runs READ_LAT=1/STARVE_MAX=8 and is checked every cycle
// against a transaction-level model; instance u_dut2 runs READ_LAT=3 for the
// long-latency DMA load. Honours MIPS_DMEM_ARB_ALIGN_CHK_EN when defined.
module tb_mips_dmem_arbiter;

  localparam int RL   = 1;
  localparam int RL2  = 3;
  localparam int SMAX = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        core_req, core_we, dma_req, dma_we;
  logic [31:0] core_addr, core_wdata, dma_addr, dma_wdata;
  logic [31:0] core_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        core_ack, core_stall, dma_ack, mem_re, mem_we;

  logic        u2_dma_req, u2_dma_we;
  logic [31:0] u2_dma_addr, u2_dma_wdata;
  logic [31:0] u2_core_rdata, u2_dma_rdata, u2_mem_addr, u2_mem_wdata, u2_mem_rdata;
  logic        u2_core_ack, u2_core_stall, u2_dma_ack, u2_mem_re, u2_mem_we;

`ifdef MIPS_DMEM_ARB_ALIGN_CHK_EN
  logic core_err, dma_err, u2_core_err, u2_dma_err;
`endif

  mips_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(RL), .STARVE_MAX(SMAX)) u_dut (
    .GlobalClock(clk), .GlobalReset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_ack(core_ack), .core_stall(core_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef MIPS_DMEM_ARB_ALIGN_CHK_EN
    , .core_err(core_err), .dma_err(dma_err)
`endif
  );

  mips_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(RL2), .STARVE_MAX(SMAX)) u_dut2 (
    .GlobalClock(clk), .GlobalReset(reset),
    .core_req(1'b0), .core_we(1'b0), .core_addr(32'h0), .core_wdata(32'h0),
    .core_rdata(u2_core_rdata), .core_ack(u2_core_ack), .core_stall(u2_core_stall),
    .dma_req(u2_dma_req), .dma_we(u2_dma_we), .dma_addr(u2_dma_addr), .dma_wdata(u2_dma_wdata),
    .dma_rdata(u2_dma_rdata), .dma_ack(u2_dma_ack),
    .mem_re(u2_mem_re), .mem_we(u2_mem_we), .mem_addr(u2_mem_addr), .mem_wdata(u2_mem_wdata),
    .mem_rdata(u2_mem_rdata)
`ifdef MIPS_DMEM_ARB_ALIGN_CHK_EN
    , .core_err(u2_core_err), .dma_err(u2_dma_err)
`endif
  );

  // Initial memory image shared by both memories and the reference model
  function automatic logic [31:0] init_word(input int idx);
    if (idx == 4)  return 32'hDEADBEEF;
    if (idx == 16) return 32'hCAFEF00D;
    return 32'hA5A50000 | 32'(idx);
  endfunction

  // Memory for u_dut: write on mem_we, read data appears RL cycles after mem_re
  logic [31:0] mem1 [0:127];
  logic [31:0] pipe1 [0:3];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) mem1[i] <= init_word(i);
    end else if (mem_we) begin
      mem1[mem_addr[8:2]] <= mem_wdata;
    end
    pipe1[0] <= mem_re ? mem1[mem_addr[8:2]] : 32'hBAD0BAD0;
    for (int k = 1; k < 4; k++) pipe1[k] <= pipe1[k-1];
  end
  assign mem_rdata = pipe1[RL-1];

  // Memory for u_dut2 with its longer read latency
  logic [31:0] mem2 [0:127];
  logic [31:0] pipe2 [0:3];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) mem2[i] <= init_word(i);
    end else if (u2_mem_we) begin
      mem2[u2_mem_addr[8:2]] <= u2_mem_wdata;
    end
    pipe2[0] <= u2_mem_re ? mem2[u2_mem_addr[8:2]] : 32'hBAD0BAD0;
    for (int k = 1; k < 4; k++) pipe2[k] <= pipe2[k-1];
  end
  assign u2_mem_rdata = pipe2[RL2-1];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Transaction-level model: each grant schedules a strobe and an ack cycle
  logic        model_on = 1'b0;
  logic        busy = 1'b0;
  int          strobe_at = 0, ack_at = 0, starve = 0;
  logic        m_owner = 1'b0, m_we = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [31:0] ref_mem [0:127];
  logic [31:0] exp_rd [0:1];

  initial begin
    logic e_re, e_we, e_cack, e_dack, gd;
    forever begin
      @(negedge clk);
      cyc++;
      if (model_on) begin
        e_re   = busy && !m_err && cyc == strobe_at && !m_we;
        e_we   = busy && !m_err && cyc == strobe_at && m_we;
        e_cack = busy && cyc == ack_at && m_owner == 1'b0;
        e_dack = busy && cyc == ack_at && m_owner == 1'b1;
        if (busy && cyc == ack_at && !m_we && !m_err) exp_rd[m_owner] = ref_mem[m_addr[8:2]];
        checkOutput("mem_re", 32'(mem_re), 32'(e_re));
        checkOutput("mem_we", 32'(mem_we), 32'(e_we));
        checkOutput("core_ack", 32'(core_ack), 32'(e_cack));
        checkOutput("dma_ack", 32'(dma_ack), 32'(e_dack));
        checkOutput("core_rdata", core_rdata, exp_rd[0]);
        checkOutput("dma_rdata", dma_rdata, exp_rd[1]);
        checkOutput("core_stall", 32'(core_stall), 32'(core_req & ~e_cack));
`ifdef MIPS_DMEM_ARB_ALIGN_CHK_EN
        checkOutput("core_err", 32'(core_err), 32'(e_cack & m_err));
        checkOutput("dma_err", 32'(dma_err), 32'(e_dack & m_err));
`endif
        if (e_re || e_we) begin
          checkOutput("mem_addr", mem_addr, m_addr);
          if (e_we) begin
            checkOutput("mem_wdata", mem_wdata, m_wdata);
            ref_mem[m_addr[8:2]] = m_wdata;
          end
        end
      end
      if (reset) begin
        model_on = 1'b1;
        busy     = 1'b0;
        starve   = 0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
      end else if (model_on) begin
        if (busy && cyc == ack_at) begin
          busy = 1'b0;
        end else if (!busy) begin
          if (core_req || dma_req) begin
            gd = dma_req && (!core_req || starve == SMAX);
            if (gd || !dma_req) starve = 0;
            else starve = (starve >= SMAX) ? SMAX : starve + 1;
            m_owner = gd;
            m_we    = gd ? dma_we : core_we;
            m_addr  = gd ? dma_addr : core_addr;
            m_wdata = gd ? dma_wdata : core_wdata;
`ifdef MIPS_DMEM_ARB_ALIGN_CHK_EN
            m_err = (m_addr[1:0] != 2'b00);
`else
            m_err = 1'b0;
`endif
            busy      = 1'b1;
            strobe_at = cyc + 1;
            ack_at    = m_err ? cyc + 1 : (m_we ? cyc + 2 : cyc + 2 + RL);
          end else begin
            starve = 0;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic creq, input logic cwe, input logic [31:0] caddr,
                               input logic [31:0] cwdata, input logic dreq, input logic dwe,
                               input logic [31:0] daddr, input logic [31:0] dwdata);
    core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwdata;
    dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwdata;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n - 1) nextCycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acks;
    logic [31:0] order;
    int ack_core_cnt;
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    u2_dma_req = 0; u2_dma_we = 0; u2_dma_addr = 0; u2_dma_wdata = 0;
    repeat (3) nextCycle();
    reset = 1'b0;
    negs(1);
    checkOutput("rst_core_ack", 32'(core_ack), 0);
    checkOutput("rst_dma_ack", 32'(dma_ack), 0);
    checkOutput("rst_mem_re", 32'(mem_re), 0);
    checkOutput("rst_mem_we", 32'(mem_we), 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_core_rdata", core_rdata, 0);

    $display("[TB] core load 0x10");
    idleCycles(2);
    nextCycle();
    applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0);
    negs(1);
    checkOutput("ld_stall_c", 32'(core_stall), 1);
    negs(1);
    checkOutput("ld_mem_re_c1", 32'(mem_re), 1);
    checkOutput("ld_mem_addr_c1", mem_addr, 32'h10);
    negs(1);
    checkOutput("ld_stall_c2", 32'(core_stall), 1);
    checkOutput("ld_ack_c2", 32'(core_ack), 0);
    negs(1);
    checkOutput("ld_ack_c3", 32'(core_ack), 1);
    checkOutput("ld_rdata_c3", core_rdata, 32'hDEADBEEF);
    checkOutput("ld_stall_c3", 32'(core_stall), 0);

    $display("[TB] core store 0x20");
    idleCycles(2);
    applyStimulus(1, 1, 32'h20, 32'h1234, 0, 0, 0, 0);
    negs(2);
    checkOutput("st_mem_we_c1", 32'(mem_we), 1);
    checkOutput("st_mem_re_c1", 32'(mem_re), 0);
    checkOutput("st_mem_addr_c1", mem_addr, 32'h20);
    checkOutput("st_mem_wdata_c1", mem_wdata, 32'h1234);
    negs(1);
    checkOutput("st_ack_c2", 32'(core_ack), 1);

    $display("[TB] dma load 0x20");
    idleCycles(2);
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h20, 0);
    negs(4);
    checkOutput("dld_ack_c3", 32'(dma_ack), 1);
    checkOutput("dld_rdata_c3", dma_rdata, 32'h1234);
    checkOutput("dld_core_ack_c3", 32'(core_ack), 0);
    checkOutput("dld_core_rdata_c3", core_rdata, 32'hDEADBEEF);

    $display("[TB] starvation guard");
    idleCycles(2);
    applyStimulus(1, 1, 32'h100, 32'h1, 1, 1, 32'h104, 32'h2);
    acks = 0;
    order = '0;
    for (int t = 0; t < 200 && acks < 18; t++) begin
      negs(1);
      if (core_ack || dma_ack) begin
        order[acks] = dma_ack;
        acks++;
      end
    end
    checkOutput("starve_ack_count", 32'(acks), 18);
    checkOutput("starve_grant_order", order, 32'h0002_0100);

    $display("[TB] reset during WAIT");
    idleCycles(2);
    applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0);
    nextCycle();
    nextCycle();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    negs(1);
    checkOutput("rw_core_ack", 32'(core_ack), 0);
    checkOutput("rw_mem_re", 32'(mem_re), 0);
    checkOutput("rw_mem_addr", mem_addr, 0);
    checkOutput("rw_mem_wdata", mem_wdata, 0);
    checkOutput("rw_core_rdata", core_rdata, 0);
    checkOutput("rw_dma_rdata", dma_rdata, 0);
    negs(1);
    checkOutput("rw_regrant_re", 32'(mem_re), 1);
    negs(1);
    checkOutput("rw_ack_early", 32'(core_ack), 0);
    negs(1);
    checkOutput("rw_ack", 32'(core_ack), 1);
    checkOutput("rw_rdata", core_rdata, 32'hDEADBEEF);

    $display("[TB] READ_LAT=3 dma load 0x40");
    idleCycles(2);
    u2_dma_req = 1; u2_dma_we = 0; u2_dma_addr = 32'h40; u2_dma_wdata = 0;
    ack_core_cnt = 0;
    negs(1);
    for (int k = 1; k <= 5; k++) begin
      negs(1);
      if (u2_core_ack) ack_core_cnt++;
      if (k == 1) checkOutput("l3_mem_re_c1", 32'(u2_mem_re), 1);
      if (k == 4) checkOutput("l3_ack_c4", 32'(u2_dma_ack), 0);
    end
    checkOutput("l3_ack_c5", 32'(u2_dma_ack), 1);
    checkOutput("l3_rdata_c5", u2_dma_rdata, 32'hCAFEF00D);
    checkOutput("l3_core_ack_none", 32'(ack_core_cnt), 0);
    checkOutput("l3_core_rdata", u2_core_rdata, 0);
    nextCycle();
    u2_dma_req = 0;

`ifdef MIPS_DMEM_ARB_ALIGN_CHK_EN
    $display("[TB] misaligned core load 0x13");
    idleCycles(2);
    applyStimulus(1, 0, 32'h13, 0, 0, 0, 0, 0);
    negs(2);
    checkOutput("al_ack_c1", 32'(core_ack), 1);
    checkOutput("al_err_c1", 32'(core_err), 1);
    checkOutput("al_mem_re_c1", 32'(mem_re), 0);
    checkOutput("al_mem_we_c1", 32'(mem_we), 0);
    checkOutput("al_rdata_c1", core_rdata, 32'hDEADBEEF);
`endif

    idleCycles(3);
    negs(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_dmem_arbiter.md
Name: mips_dmem_arbiter

Overview:
Shares the single data-memory port between the core's load/store path and a DMA/program-loader requester.
- Registered FSM per access: issue, wait for read latency, respond.
- Fixed core priority, with a starvation guard that forces a DMA grant.
- Drives core_stall so the PC and register-file write hold while a core access is pending.

Parameters:
ADDR_W, 32, address width of all ports.
DATA_W, 32, data width of all ports.
READ_LAT, 1, memory read latency in cycles (legal 1..4): mem_rdata valid READ_LAT cycles after the mem_re cycle.
STARVE_MAX, 8, consecutive core grants allowed while dma_req is pending before DMA is forced (legal 1..15).

Ports:
GlobalClock  in  1  single clock, rising edge.
GlobalReset  in  1  synchronous, active-high reset.
core_req  in  1  core access request; held until core_ack.
core_we  in  1  1 = store, 0 = load.
core_addr  in  ADDR_W  byte address.
core_wdata  in  DATA_W  store data.
core_rdata  out  DATA_W  load data; valid while core_ack is high.
core_ack  out  1  one-cycle completion pulse.
core_stall  out  1  combinational: core_req & ~core_ack.
dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack  (same meaning, DMA side; no stall output).
mem_re  out  1  memory read strobe.
mem_we  out  1  memory write strobe.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset: all outputs 0; state IDLE; starvation counter 0; owner = core. Reset mid-access abandons the access and produces no ack. A write already strobed is not undone.
- States:
  - IDLE: arbitrate; if any request is present, latch owner/we/addr/wdata and go to ISSUE.
  - ISSUE: drive mem_re or mem_we for exactly 1 cycle, plus mem_addr/mem_wdata. Read goes to WAIT; write goes to RESP.
  - WAIT: stay READ_LAT cycles. On the last WAIT edge, capture mem_rdata into the owner's rdata register. Then go to RESP.
  - RESP: owner's ack = 1 for 1 cycle. Then go to IDLE.
- Latency from request sampled in IDLE cycle c:
  - write: ack in cycle c+2.
  - read: ack in cycle c+2+READ_LAT.
  - Throughput is one access per 3 cycles (write) or 3+READ_LAT cycles (read).
- mem_re and mem_we are never both high. Both are 0 outside ISSUE. mem_addr/mem_wdata hold their last value otherwise.
- Arbitration in IDLE:
  - Core wins if core_req=1, unless starve_cnt == STARVE_MAX and dma_req=1; in that case DMA wins.
- Starvation counter:
  - Increments on each core grant made while dma_req=1.
  - Clears on a DMA grant, or on any IDLE cycle with dma_req=0.
  - Saturates at STARVE_MAX.
- rdata registers hold their value until the next read by the same owner. The non-owner's rdata and ack are unaffected.
- A requester still holding req in the cycle after its ack (IDLE) starts a new access.
- Requests dropped before ack are a protocol violation; behaviour is undefined. The arbiter completes the latched access regardless.
- The full address passes to memory unchanged (word alignment is the requester's duty unless the optional feature is compiled in).

Optional Feature:
MIPS_DMEM_ARB_ALIGN_CHK_EN
- Defined:
  - Adds outputs core_err and dma_err (1 bit each).
  - A request with addr[1:0] != 0 skips ISSUE/WAIT and goes IDLE -> RESP. No mem strobe is driven.
  - In RESP, ack=1 and err=1; rdata is unchanged.
  - The grant still counts toward starvation accounting.
- Undefined: no err ports and no check; misaligned addresses are passed through.

Decomposition:
- Package mips_mem_pkg holds:
  - FSM state enum (IDLE, ISSUE, WAIT, RESP);
  - owner constants OWN_CORE=0, OWN_DMA=1;
  - default ADDR_W/DATA_W;
  - READ_LAT/STARVE_MAX legal-range constants.
- One natural sub-module: mips_arb_starve_cnt, a 4-bit saturating counter with inc/clr/sat ports.
- The wait counter stays inline in the FSM.

Test Plan:
- READ_LAT=1, core load addr 0x10 with memory model returning 0xDEADBEEF -> mem_re in cycle c+1, core_ack and core_rdata=0xDEADBEEF in c+3, core_stall high c..c+2.
- Core store addr 0x20 data 0x1234 -> mem_we=1, mem_addr=0x20, mem_wdata=0x1234 in c+1, core_ack in c+2, no mem_re.
- core_req and dma_req held high continuously, STARVE_MAX=8 -> grant order is 8 core accesses, then 1 DMA, then repeats; dma_ack never missing for more than 8 core acks.
- READ_LAT=3, DMA load addr 0x40 -> dma_ack in c+5; core_ack stays 0; core_rdata unchanged.
- GlobalReset asserted during WAIT -> next cycle all outputs 0, state IDLE, no ack. After release, the pending core_req is granted afresh.
- With MIPS_DMEM_ARB_ALIGN_CHK_EN, core load addr 0x13 -> core_ack=core_err=1 in c+1, mem_re/mem_we stay 0.
